offchip_traffic_monitor: RTL
============================

# offchip_traffic_monitor

Synthesisable, parametrised monitor that counts accepted handshake beats and data bit-toggles on NUM_CH valid/ready streams at the accelerator's off-chip boundary. It provides the energy proxy for the activation-in, weight-in and output streams in silicon and in gate-level simulation. It generalises the bench-only per-stream beat counters with:

- configurable channel count and widths;
- a measurement window;
- Hamming-distance toggle counting;
- saturation with sticky overflow flags;
- a registered read port.

## Interface
- NUM_CH, 3, number of monitored streams (ch0 activations in, ch1 weights in, ch2 output)
- DATA_W, 64, data width per channel (equals cfg.MEM_BW)
- CNT_W, 32, width of every counter
- TOGGLE_EN, 1, 1 enables toggle counters; 0 ties them to zero

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- mon_valid  in  NUM_CH  per-channel valid
- mon_ready  in  NUM_CH  per-channel ready; tie to 1 for channels without ready (output stream)
- mon_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- start  in  1  open a measurement window
- stop  in  1  close the window
- state_o  out  2  window state: 0 IDLE, 1 RUN, 2 DONE
- rd_sel  in  $clog2(NUM_CH)+1  channel to read
- rd_beats  out  CNT_W  registered beat count of rd_sel
- rd_toggles  out  CNT_W  registered toggle count of rd_sel
- rd_ovf  out  1  registered sticky overflow of rd_sel
- run_cycles  out  CNT_W  number of cycles spent in RUN, saturating

## Operation
**Accepted beat.** Channel c has an accepted beat in a cycle when mon_valid[c] && mon_ready[c] is sampled at the rising edge while the state is RUN.

**State machine.**
- IDLE: all counters hold. start -> RUN. stop is ignored.
- RUN: counting is active. stop -> DONE. start is ignored.
- DONE: counters are frozen and readable. start -> RUN, with all counters, overflow flags and prev_data cleared in the same edge. stop is ignored.
- start and stop together: IDLE and DONE take start; RUN takes stop.

**Beat counter.** On an accepted beat, beats[c] += 1.

**Toggle counter.**
- On an accepted beat, toggles[c] += popcount(mon_data[c] ^ prev_data[c]), then prev_data[c] <= mon_data[c].
- prev_data is updated only on accepted beats.
- The first beat after reset or start is compared against all-zero.
- The per-beat increment is in 0..DATA_W.

**Saturation.**
- All adds saturate at 2^CNT_W-1.
- Any add that would exceed the maximum sets ovf[c], which stays set until reset or start.
- run_cycles saturates the same way but has no flag.

**Read port.**
- rd_beats, rd_toggles and rd_ovf show the value of rd_sel as of the previous edge.
- rd_sel >= NUM_CH reads all zeros.
- Reading is legal in every state; reading during RUN returns live values.

**Reset.** rst returns the state to IDLE and clears every counter, prev_data, ovf flag, rd_* output and run_cycles to 0. state_o reads 0.

**Tie-off.** With TOGGLE_EN=0, the toggle counters and the popcount logic are removed, and rd_toggles is constant 0.

## Timing
- start sampled at edge t: state is RUN after t. Beats sampled at edge t are not counted.
- stop sampled at edge t while in RUN: beats sampled at edge t are counted, and state is DONE after t.
- Counter update latency: 1 cycle. A beat sampled at edge t is visible in the internal counter after t, and on rd_* after t+1 (the read register adds 1 cycle).
- run_cycles increments once per edge at which the state is RUN, including the edge at which stop is sampled.
- rst asserted mid-window has priority over start, stop and beats in the same cycle.
- Throughput: every channel can accept one beat per cycle simultaneously, with no back-pressure on the monitored streams.
- Popcount timing: a single-cycle combinational popcount plus a CNT_W add must close at the core clock. DATA_W=64 is the sizing case.

## Test plan
- **Reset values.** rst for 2 cycles -> state_o=0, run_cycles=0, rd_beats=rd_toggles=0 and rd_ovf=0 for every rd_sel.
- **Beat counting.** start, then 10 cycles with ch0 valid&ready, ch1 valid with ready low, and ch2 valid with ready tied 1, then stop. Read ch0/1/2 -> beats 10/0/10; run_cycles=11 (10 data cycles plus the stop edge).
- **Toggle counting.** ch0 beats with data 0x0, 0xFF, 0xF0, then 0xF0 again -> toggles 0+8+4+0=12.
- **Window edges.** A beat coincident with start is not counted; a beat coincident with stop is counted. A beat after DONE leaves the counts unchanged.
- **Saturation.** With CNT_W=4, 20 accepted ch1 beats -> rd_beats=15 and rd_ovf=1. A new start -> counters 0 and rd_ovf=0.
- **Restart and reset priority.** start in DONE clears the previous counts. rst asserted in the same cycle as start and beats -> state IDLE, all counters 0. rd_sel=3 with NUM_CH=3 -> all-zero read.

Source files
------------

// File: rtl/offchip_traffic_monitor.sv
// Off-chip boundary traffic monitor: per-channel accepted-beat and data-toggle
// counters over a start/stop measurement window, with a registered read port.

module offchip_traffic_monitor_ch #(
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 32,
  parameter int TOGGLE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              beat,
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  beats,
  output logic [CNT_W-1:0]  toggles,
  output logic              ovf
);
  localparam int IW = $clog2(DATA_W + 1);
  localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam logic [SW-1:0] MAX = SW'({CNT_W{1'b1}});

  logic b_ovf, t_ovf;

  // beats can only grow by one, so "already at max" is the overflow condition
  assign b_ovf = &beats;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beats <= '0;
      ovf   <= 1'b0;
    end else if (beat) begin
      if (!b_ovf) beats <= beats + CNT_W'(1);
      ovf <= ovf | b_ovf | t_ovf;
    end
  end

  generate
    if (TOGGLE_EN != 0) begin : g_tog
      logic [DATA_W-1:0] prev;
      logic [IW-1:0]     pop;
      logic [SW-1:0]     sum;

      always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_W; i++) pop = pop + IW'(data[i] ^ prev[i]);
      end

      assign sum   = SW'(toggles) + SW'(pop);
      assign t_ovf = (sum > MAX);

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          prev    <= '0;
          toggles <= '0;
        end else if (beat) begin
          prev    <= data;
          toggles <= t_ovf ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        end
      end
    end else begin : g_notog
      assign t_ovf   = 1'b0;
      assign toggles = '0;
    end
  endgenerate
endmodule

module offchip_traffic_monitor #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 32,
  parameter int TOGGLE_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        mon_valid,
  input  logic [NUM_CH-1:0]        mon_ready,
  input  logic [NUM_CH*DATA_W-1:0] mon_data,
  input  logic                     start,
  input  logic                     stop,
  output logic [1:0]               state_o,
  input  logic [$clog2(NUM_CH):0]  rd_sel,
  output logic [CNT_W-1:0]         rd_beats,
  output logic [CNT_W-1:0]         rd_toggles,
  output logic                     rd_ovf,
  output logic [CNT_W-1:0]         run_cycles
);
  localparam int SEL_W = $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic                         run, clr;
  logic [NUM_CH-1:0][CNT_W-1:0] beats, toggles;
  logic [NUM_CH-1:0]            ovf;
  logic [CNT_W-1:0]             sel_beats, sel_toggles;
  logic                         sel_ovf;

  assign run     = (state == RUN);
  assign clr     = (state == DONE) && start;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_cycles <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (stop) state <= DONE;
          if (run_cycles != '1) run_cycles <= run_cycles + CNT_W'(1);
        end
        DONE: if (start) begin
          state      <= RUN;
          run_cycles <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      offchip_traffic_monitor_ch #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .TOGGLE_EN(TOGGLE_EN)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .beat   (run && mon_valid[c] && mon_ready[c]),
        .data   (mon_data[c*DATA_W +: DATA_W]),
        .beats  (beats[c]),
        .toggles(toggles[c]),
        .ovf    (ovf[c])
      );
    end
  endgenerate

  // out-of-range selects fall through to zero
  always_comb begin
    sel_beats   = '0;
    sel_toggles = '0;
    sel_ovf     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_sel == SEL_W'(c)) begin
        sel_beats   = beats[c];
        sel_toggles = toggles[c];
        sel_ovf     = ovf[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_beats   <= '0;
      rd_toggles <= '0;
      rd_ovf     <= 1'b0;
    end else begin
      rd_beats   <= sel_beats;
      rd_toggles <= sel_toggles;
      rd_ovf     <= sel_ovf;
    end
  end
endmodule
